// File: rtl/deskew_pkg.sv
// Shared constants for the lane deskew aligner: default geometry and output FIFO sizing.
package deskew_pkg;

    localparam int LANES_DEF  = 8;
    localparam int WIDTH_DEF  = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/deskew_lane_delay.sv
// Fixed-depth valid+data delay line for one lane; DEPTH=0 is a pure pass-through.
module lane_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ctl;
            assign w_unused_ctl = clk ^ rst_n;
            assign o_valid      = i_valid;
            assign o_data       = i_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] r_vld;
            logic [WIDTH-1:0] r_dat [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Data path is left unreset; the valid pipe alone qualifies it.
            always_ff @(posedge clk) begin
                r_dat[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end

            assign o_valid = r_vld[DEPTH-1];
            assign o_data  = r_dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/deskew_aligner.sv
// Realigns LANES staggered lane slices into whole words and queues them in a 2-entry FIFO.
// Define DESKEW_ERR_CHECK_EN to require all lane valids and flag partial alignment.
module deskew_aligner
    import deskew_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       i_valid,
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic                   o_overflow,
    output logic                   o_skew_err,
    input  logic                   i_clr_err
);

    logic [LANES-1:0]       w_dvalid;
    logic [LANES*WIDTH-1:0] w_ddata;
    logic                   w_wr;

    // Lane k trails lane 0 by k cycles, so it needs LANES-1-k stages to catch up.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_delay #(
            .DEPTH (LANES - 1 - k),
            .WIDTH (WIDTH)
        ) u_dly (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (i_valid[k]),
            .i_data  (i_data[k*WIDTH +: WIDTH]),
            .o_valid (w_dvalid[k]),
            .o_data  (w_ddata[k*WIDTH +: WIDTH])
        );
    end

`ifdef DESKEW_ERR_CHECK_EN
    logic w_partial;
    logic r_skew;

    assign w_wr      = &w_dvalid;
    assign w_partial = (|w_dvalid) & ~w_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skew <= 1'b0;
        end else begin
            r_skew <= w_partial | (r_skew & ~i_clr_err);
        end
    end

    assign o_skew_err = r_skew;
`else
    logic w_unused_vld;

    assign w_wr         = w_dvalid[0];
    assign w_unused_vld = ^w_dvalid[LANES-1:1];
    assign o_skew_err   = 1'b0;
`endif

    logic [LANES*WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    assign o_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = o_valid & o_ready;
    // A pop in the same cycle frees the slot the incoming word lands in.
    assign w_push  = w_wr & (~w_full | w_pop);
    assign w_drop  = w_wr & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= w_drop | (r_ovf & ~i_clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_ddata;
        end
    end

    assign o_data     = r_mem[r_rptr];
    assign o_overflow = r_ovf;

endmodule

// File: doc/deskew_aligner.md
DESKEW_ALIGNER -- requirements
Module: deskew_aligner

Interface
REQ-001 The block SHALL have parameter LANES, default 8, giving the number of skewed input lanes (legal range 2..32).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the data bits per lane.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_valid, input, LANES bits: the per-lane valid; lane k carries the word's slice k cycles after lane 0.
REQ-006 The block SHALL have port i_data, input, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port o_valid, output, 1 bit: an aligned word is present on o_data.
REQ-008 The block SHALL have port o_ready, input, 1 bit: the consumer accepts the word on cycles where o_valid and o_ready are both high.
REQ-009 The block SHALL have port o_data, output, LANES*WIDTH bits: the aligned word, using the same lane packing as i_data.
REQ-010 The block SHALL have port o_overflow, output, 1 bit: sticky flag set when an aligned word was dropped because the buffer was full.
REQ-011 The block SHALL have port o_skew_err, output, 1 bit: sticky flag set on partial lane-valid alignment.
REQ-012 The block SHALL have port i_clr_err, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-013 Lane k SHALL be delayed by exactly LANES-1-k registers, and lane LANES-1 SHALL be zero-delay, so that all slices of one word coincide at the alignment point.
REQ-014 The aligned word SHALL be written into a 2-entry output FIFO when all delayed valids are high.
REQ-015 The input side SHALL have no backpressure, and each lane SHALL accept a slice every cycle.
REQ-016 Latency: with an empty FIFO, o_valid SHALL assert exactly LANES cycles after lane 0's input cycle.
REQ-017 o_data SHALL be held stable while o_valid=1 and o_ready=0.
REQ-018 Back-to-back aligned words with o_ready held at 1 SHALL stream at 1 word per cycle with no bubbles.
REQ-019 When the FIFO is full and an aligned word arrives in the same cycle as a pop, the word SHALL be written without overflow.
REQ-020 When the FIFO is full, no pop occurs and an aligned word arrives, the word SHALL be dropped, o_overflow SHALL set on the next edge, and FIFO contents SHALL be unchanged.
REQ-021 When some but not all delayed valids are high, no write SHALL occur and o_skew_err SHALL set (this applies only when error checking is compiled in).
REQ-022 i_clr_err SHALL clear the sticky flags on the next edge; when clear and a new set event coincide, the set SHALL win.
REQ-023 FIFO occupancy SHALL be 0..2 with wrap-around pointers; pop on empty SHALL be impossible because o_valid=0 when the FIFO is empty.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously clear all delay-line valids, the FIFO pointers and count, o_valid, o_overflow and o_skew_err to 0.
REQ-025 Data registers SHALL NOT be required to reset, and o_data SHALL be don't-care while o_valid=0.
REQ-026 Reset asserted mid-word SHALL discard all partially aligned slices, and no stale word SHALL appear after deassertion.

Configuration
REQ-027 With the macro DESKEW_ERR_CHECK_EN defined, the write condition SHALL be AND of all delayed valids, and a partial match SHALL set o_skew_err.
REQ-028 Without DESKEW_ERR_CHECK_EN, the write condition SHALL be the delayed lane-0 valid only, o_skew_err SHALL be tied 0, and the comparison logic SHALL be absent.

Structure
REQ-029 A shared package deskew_pkg SHALL hold the default LANES and WIDTH constants and the FIFO depth constant (2).
REQ-030 A sub-module lane_delay (parameters DEPTH, WIDTH; valid plus data) SHALL implement each per-lane delay, and DEPTH=0 SHALL be a pass-through.

Verification
REQ-031 A single word fed with LANES=4 and lane k driven at cycle k with data 0x1000+k, o_ready=1 -> o_valid SHALL be high at cycle 4 only and o_data SHALL be {0x1003,0x1002,0x1001,0x1000}.
REQ-032 A continuous stream of 20 words with o_ready=1 -> 20 consecutive o_valid cycles, in order, with no flags set.
REQ-033 o_ready=0 with 3 words sent -> first 2 words retained, third dropped, o_overflow=1; raising o_ready -> exactly 2 words delivered.
REQ-034 Lane 2 valid suppressed for one word (DESKEW_ERR_CHECK_EN defined) -> no o_valid for that word and o_skew_err=1; i_clr_err pulse -> o_skew_err=0.
REQ-035 rst_n asserted with 2 lanes of a word in flight, then released -> no o_valid ever appears for that word and all flags read 0.
REQ-036 Pop and arrival coinciding on a full FIFO -> occupancy stays 2 and o_overflow stays 0.
